// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state encoding,
// the fixed funct3 used for instruction fetches, and requester IDs.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  // Fetches are always full 32-bit words.
  localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified instruction/data memory between the IF
// fetch port and the MEM-stage load/store port with a request/grant handshake.
// Data accesses win ties so the older instruction drains first; a fetch is
// forced through after STARVE_MAX consecutive data grants taken while it waits.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request (held until if_gnt) and PC
//   if_gnt/if_rdata          one-cycle completion pulse, registered instruction
//   dm_req/dm_we/dm_funct3   data request (held until dm_gnt), store/load, size
//   dm_addr/dm_wdata         data address and store data
//   dm_gnt/dm_rdata          one-cycle completion pulse, registered load data
//   stall_if/stall_mem       combinational per-stage stalls (req & ~gnt)
//   mem_addr/mem_read/mem_write/mem_funct3/mem_wdata  registered memory command
//   mem_rdata                memory read data, valid on the last busy cycle
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LAT        = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_funct3,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int unsigned STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  if (LAT == 0) begin : g_bad_lat
    $error("mem_port_arbiter: LAT must be >= 1");
  end

  arb_state_t          state;
  logic [CNT_W-1:0]    cnt;
  logic [STARVE_W-1:0] starve_cnt;

  logic    if_elig;
  logic    dm_elig;
  logic    any_elig;
  logic    starved;
  logic    acc_done;
  req_id_t winner;

  // A port whose grant is pulsing this cycle is still showing its old request.
  always_comb begin
    if_elig  = if_req & ~if_gnt;
    dm_elig  = dm_req & ~dm_gnt;
    any_elig = if_elig | dm_elig;
    starved  = (starve_cnt == STARVE_W'(STARVE_MAX));
    winner   = (if_elig && (!dm_elig || starved)) ? REQ_IF : REQ_DM;
    acc_done = (state != IDLE) && (cnt == '0);
  end

  assign stall_if  = if_req & ~if_gnt;
  assign stall_mem = dm_req & ~dm_gnt;

  // Arbitration FSM, access counter and registered memory command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      if_gnt     <= 1'b0;
      dm_gnt     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      mem_addr   <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_funct3 <= '0;
      mem_wdata  <= '0;
    end else begin
      if_gnt <= 1'b0;
      dm_gnt <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= CNT_W'(LAT - 1);
          if (any_elig && winner == REQ_IF) begin
            state      <= BUSY_IF;
            mem_addr   <= if_addr;
            mem_read   <= 1'b1;
            mem_write  <= 1'b0;
            mem_funct3 <= FETCH_FUNCT3;
          end else if (any_elig) begin
            state      <= BUSY_DM;
            mem_addr   <= dm_addr;
            mem_read   <= ~dm_we;
            mem_write  <= dm_we;
            mem_funct3 <= dm_funct3;
            mem_wdata  <= dm_wdata;
          end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            if (state == BUSY_IF) begin
              if_rdata <= mem_rdata;
              if_gnt   <= 1'b1;
            end else begin
              if (!mem_write) dm_rdata <= mem_rdata;
              dm_gnt <= 1'b1;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Counts data grants taken while a fetch is waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!if_req || (acc_done && state == BUSY_IF)) begin
      starve_cnt <= '0;
    end else if (acc_done && state == BUSY_DM && !starved) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

endmodule
